pipe_stage3_butterfly: RTL

- Downstream neighbour of the stage-2 timing wrapper; consumes its per-lane scalar operand pair (operand1/operand2) and produces butterfly results (a+b, a−b) for the next transform stage.
- Registers the arithmetic, buffers results in a small FIFO and hands them on with valid/ready.
- A start/finished frame FSM brackets one transform pass of N elements.

---
 rtl/dal_pipe_pkg.sv | 42 ++++
 rtl/pipe_stage3_fifo.sv | 55 +++++
 rtl/pipe_stage3_butterfly.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dal_pipe_pkg.sv
// Shared types and helpers for the stage-3 butterfly datapath.
// Saturating helpers back the optional PIPE_STAGE3_SAT_EN build.
package dal_pipe_pkg;

    localparam int WIDTH = 16;
    localparam int PARALLEL_SIZE = 2;

    typedef logic [PARALLEL_SIZE-1:0][WIDTH-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // MSB of the result flags a clip, low WIDTH bits carry the value
    function automatic logic [WIDTH:0] sat_clip(input logic [WIDTH:0] x);
        logic [WIDTH:0] r;
        if (x[WIDTH] != x[WIDTH-1]) begin
            r = {1'b1, x[WIDTH], {(WIDTH-1){~x[WIDTH]}}};
        end else begin
            r = {1'b0, x[WIDTH-1:0]};
        end
        return r;
    endfunction

    function automatic logic [WIDTH:0] sat_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return sat_clip({a[WIDTH-1], a} + {b[WIDTH-1], b});
    endfunction

    function automatic logic [WIDTH:0] sat_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return sat_clip({a[WIDTH-1], a} - {b[WIDTH-1], b});
    endfunction

endpackage

// File: rtl/pipe_stage3_fifo.sv
// Small synchronous FIFO carrying {sum,diff} butterfly results.
// Head is a direct read of the storage slot at the read pointer.
module pipe_stage3_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic full;
    logic push_ok;
    logic pop_ok;

    assign full = (32'(count) == 32'(DEPTH));
    assign empty = (count == '0);
    assign pop_ok = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage3_butterfly.sv
// Stage-3 butterfly: per-lane a+b / a-b, one register stage, output FIFO.
// Define PIPE_STAGE3_SAT_EN for saturating arithmetic and sat_flag_o.
module pipe_stage3_butterfly #(
    parameter int N = 4096,
    parameter int WIDTH = 16,
    parameter int PARALLEL_SIZE = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int BEATS = N / PARALLEL_SIZE,
    localparam int CW = $clog2(BEATS) + 1,
    localparam int LW = PARALLEL_SIZE * WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [2:0]    stage_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] operand1_i,
    input  logic [LW-1:0] operand2_i,
    output logic [LW-1:0] sum_o,
    output logic [LW-1:0] diff_o,
    output logic [2:0]    stage_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] beat_cnt_o,
`ifdef PIPE_STAGE3_SAT_EN
    output logic          sat_flag_o,
`endif
    output logic          finished
);

    import dal_pipe_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [PARALLEL_SIZE-1:0][WIDTH-1:0] lanes_t;

    state_t state;
    state_t state_n;
    lanes_t a;
    lanes_t b;
    lanes_t res_sum;
    lanes_t res_diff;
    lanes_t pipe_sum;
    lanes_t pipe_diff;
    lanes_t head_sum;
    lanes_t head_diff;
    logic [2*LW-1:0] head_data;
    logic [AW:0] fifo_count;
    logic fifo_empty;
    logic pipe_valid;
    logic accept;
    logic last_beat;
    logic start_ok;

    assign a = operand1_i;
    assign b = operand2_i;

    // Reserve a slot for the beat sitting in the pipeline register
    assign in_ready = (state == RUN) &&
        ((32'(fifo_count) + 32'(pipe_valid)) < 32'(FIFO_DEPTH));
    assign accept = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt_o == CW'(BEATS - 1));
    assign start_ok = (state == IDLE) && start_i;
    assign finished = (state == DONE);
    assign out_valid = !fifo_empty;
    assign {head_sum, head_diff} = head_data;
    assign sum_o = head_sum;
    assign diff_o = head_diff;

`ifdef PIPE_STAGE3_SAT_EN
    logic [WIDTH:0] s_ext;
    logic [WIDTH:0] d_ext;
    logic clip_any;

    always_comb begin
        res_sum = '0;
        res_diff = '0;
        s_ext = '0;
        d_ext = '0;
        clip_any = 1'b0;
        for (int i = 0; i < PARALLEL_SIZE; i++) begin
            s_ext = sat_add(a[i], b[i]);
            d_ext = sat_sub(a[i], b[i]);
            res_sum[i] = s_ext[WIDTH-1:0];
            res_diff[i] = d_ext[WIDTH-1:0];
            clip_any = clip_any | s_ext[WIDTH] | d_ext[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag_o <= 1'b0;
        end else if (start_ok) begin
            sat_flag_o <= 1'b0;
        end else if (accept && clip_any) begin
            sat_flag_o <= 1'b1;
        end
    end
`else
    always_comb begin
        res_sum = '0;
        res_diff = '0;
        for (int i = 0; i < PARALLEL_SIZE; i++) begin
            res_sum[i] = a[i] + b[i];
            res_diff[i] = a[i] - b[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start_i) state_n = RUN;
            RUN: if (last_beat) state_n = DRAIN;
            DRAIN: if (!pipe_valid && fifo_empty) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_o <= '0;
            beat_cnt_o <= '0;
        end else if (start_ok) begin
            stage_o <= stage_i;
            beat_cnt_o <= '0;
        end else if (accept && (beat_cnt_o != CW'(BEATS))) begin
            beat_cnt_o <= beat_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= 1'b0;
            pipe_sum <= '0;
            pipe_diff <= '0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_sum <= res_sum;
                pipe_diff <= res_diff;
            end
        end
    end

    pipe_stage3_fifo #(
        .DATA_W(2 * LW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pipe_valid),
        .push_data({pipe_sum, pipe_diff}),
        .pop      (out_valid && out_ready),
        .head     (head_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
